req_arbiter_16: RTL and testbench

Round-robin arbiter that shares one 16-way resource between 16 requesters. Each cycle it selects at most one owner from a 16-bit request vector and presents the grant both as a one-hot vector and as a 4-bit encoded index. A grant is held while its requester keeps requesting, bounded by a programmable hold limit. The block sits in front of the 16-to-4 encoding datapath: it turns an arbitrary multi-hot request set into the strictly one-hot, registered selection that downstream logic needs.

---
 rtl/req_arbiter_16.sv | 120 ++++++++++++
 tb/tb_req_arbiter_16.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/req_arbiter_16.sv
// req_arbiter_16: round-robin arbiter that gives one shared resource to one of 16 requesters.
//
// A grant is held while its owner keeps requesting. HOLD_MAX bounds how long it is held
// (0 = unlimited). The owner's next search starts one past the last granted index.
// All outputs are registered and strictly one-hot.
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_enable     arbitration enable; low withdraws every grant on the next edge
//   i_req[15:0]  request vector, bit i = requester i
//   o_gnt[15:0]  one-hot grant, zero when nothing is granted
//   o_gnt_idx    encoded index of the o_gnt bit, zero when nothing is granted
//   o_gnt_valid  high exactly when o_gnt is non-zero
module req_arbiter_16 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_req,
  output logic [15:0] o_gnt,
  output logic [3:0]  o_gnt_idx,
  output logic        o_gnt_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // hold_cnt value on the last cycle a grant may be held
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);
  localparam bit         HoldLimited = (HOLD_MAX != 0);

  state_e      r_state;
  logic [3:0]  r_ptr;
  logic [7:0]  r_hold_cnt;
  logic [15:0] r_gnt;
  logic [3:0]  r_gnt_idx;  // doubles as the owner index while in StGrant
  logic        r_gnt_valid;

  logic        w_release;
  logic        w_timeout;
  logic        w_arb;
  logic [15:0] w_mask;
  logic [15:0] w_masked_req;
  logic [3:0]  w_cand;
  logic        w_found;
  logic [3:0]  w_win;
  logic        w_have_winner;
  logic [3:0]  w_next_idx;

  always_comb begin
    w_release = (r_state == StGrant) && !i_req[r_gnt_idx];
    w_timeout = (r_state == StGrant) && HoldLimited && (r_hold_cnt == HoldLast);
    w_arb     = (r_state == StIdle) || w_release || w_timeout;

    // A timed-out owner stands aside so others get a turn; on a coincident
    // release its request is already low, so no masking is needed.
    w_mask = 16'hFFFF;
    if (w_timeout && !w_release) begin
      w_mask[r_gnt_idx] = 1'b0;
    end
    w_masked_req = i_req & w_mask;

    // Rotating priority search from r_ptr+1; the 4-bit add wraps 15 -> 0, and
    // the last candidate checked is r_ptr itself.
    w_found = 1'b0;
    w_win   = 4'd0;
    w_cand  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      w_cand = r_ptr + 4'(i + 1);
      if (!w_found && w_masked_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end

    // Timed-out owner with no competitor keeps the resource (its req is high).
    w_have_winner = w_found || (w_timeout && !w_release);
    w_next_idx    = w_found ? w_win : r_gnt_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= 4'd15;
      r_hold_cnt  <= 8'd0;
      r_gnt       <= 16'h0000;
      r_gnt_idx   <= 4'd0;
      r_gnt_valid <= 1'b0;
    end else if (!i_enable) begin
      // ptr is deliberately retained so fairness survives an enable gap.
      r_state     <= StIdle;
      r_hold_cnt  <= 8'd0;
      r_gnt       <= 16'h0000;
      r_gnt_idx   <= 4'd0;
      r_gnt_valid <= 1'b0;
    end else if (w_arb) begin
      r_hold_cnt <= 8'd0;
      if (w_have_winner) begin
        r_state     <= StGrant;
        r_ptr       <= w_next_idx;
        r_gnt       <= 16'h0001 << w_next_idx;
        r_gnt_idx   <= w_next_idx;
        r_gnt_valid <= 1'b1;
      end else begin
        r_state     <= StIdle;
        r_gnt       <= 16'h0000;
        r_gnt_idx   <= 4'd0;
        r_gnt_valid <= 1'b0;
      end
    end else begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_req_arbiter_16.sv
module tb_req_arbiter_16;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;

  logic [15:0] gnt0, gnt4;
  logic [3:0]  idx0, idx4;
  logic        vld0, vld4;

  int n_pass  = 0;
  int n_total = 0;

  // Unlimited-hold instance and HOLD_MAX = 4 instance share the stimulus.
  req_arbiter_16 #(.HOLD_MAX(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_req(req),
    .o_gnt(gnt0), .o_gnt_idx(idx0), .o_gnt_valid(vld0)
  );

  req_arbiter_16 #(.HOLD_MAX(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_req(req),
    .o_gnt(gnt4), .o_gnt_idx(idx4), .o_gnt_valid(vld4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packed as {gnt, gnt_idx, gnt_valid}.
  task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got gnt=%h idx=%0d valid=%b, want gnt=%h idx=%0d valid=%b",
                tag, obs[20:5], obs[4:1], obs[0], exp[20:5], exp[4:1], exp[0]);
  endtask

  function automatic logic [20:0] g(input logic [15:0] gv, input logic [3:0] iv,
                                    input logic vv);
    return {gv, iv, vv};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 16'h0000;
    #12;
    chk("reset0", {gnt0, idx0, vld0}, g(16'h0000, 4'd0, 1'b0));
    chk("reset4", {gnt4, idx4, vld4}, g(16'h0000, 4'd0, 1'b0));
    rst_n  = 1'b1;
    enable = 1'b1;

    // No requests: nothing granted.
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle", {gnt0, idx0, vld0}, g(16'h0000, 4'd0, 1'b0));
    end

    // Handover and wrap-around, unlimited hold.
    req = 16'h8001;
    step();
    chk("first0", {gnt0, idx0, vld0}, g(16'h0001, 4'd0, 1'b1));
    step();
    chk("hold0", {gnt0, idx0, vld0}, g(16'h0001, 4'd0, 1'b1));
    req = 16'h8000;
    step();
    chk("handover15", {gnt0, idx0, vld0}, g(16'h8000, 4'd15, 1'b1));
    req = 16'h0001;
    step();
    chk("wrap0", {gnt0, idx0, vld0}, g(16'h0001, 4'd0, 1'b1));
    req = 16'h0000;
    step();
    chk("release_none", {gnt0, idx0, vld0}, g(16'h0000, 4'd0, 1'b0));

    // HOLD_MAX = 4 rotation between requesters 1 and 2.
    pulse_reset();
    req = 16'h0006;
    for (int k = 0; k < 12; k++) begin
      step();
      if (((k / 4) % 2) == 0)
        chk("rot_idx1", {gnt4, idx4, vld4}, g(16'h0002, 4'd1, 1'b1));
      else
        chk("rot_idx2", {gnt4, idx4, vld4}, g(16'h0004, 4'd2, 1'b1));
    end

    // Lone requester re-granted across timeouts without a gap.
    pulse_reset();
    req = 16'h0400;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("lone10", {gnt4, idx4, vld4}, g(16'h0400, 4'd10, 1'b1));
    end

    // Enable gap keeps ptr: owner 3, then next grant goes to 4.
    pulse_reset();
    req = 16'h0008;
    step();
    chk("own3", {gnt0, idx0, vld0}, g(16'h0008, 4'd3, 1'b1));
    req = 16'hFFFF;
    step();
    chk("own3_hold", {gnt0, idx0, vld0}, g(16'h0008, 4'd3, 1'b1));
    enable = 1'b0;
    step();
    chk("disabled", {gnt0, idx0, vld0}, g(16'h0000, 4'd0, 1'b0));
    enable = 1'b1;
    step();
    chk("reenable4", {gnt0, idx0, vld0}, g(16'h0010, 4'd4, 1'b1));

    // Asynchronous reset in the middle of a grant.
    pulse_reset();
    req = 16'h0100;
    step();
    chk("own8", {gnt0, idx0, vld0}, g(16'h0100, 4'd8, 1'b1));
    req = 16'hFFFF;
    step();
    chk("own8_hold", {gnt0, idx0, vld0}, g(16'h0100, 4'd8, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst0", {gnt0, idx0, vld0}, g(16'h0000, 4'd0, 1'b0));
    chk("async_rst4", {gnt4, idx4, vld4}, g(16'h0000, 4'd0, 1'b0));
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst0", {gnt0, idx0, vld0}, g(16'h0001, 4'd0, 1'b1));
    chk("post_rst4", {gnt4, idx4, vld4}, g(16'h0001, 4'd0, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
